// File: rtl/datapath_frame_arbiter.sv
// Frame-granular 2:1 arbiter in front of a shared datapath_gray instance.
// Ownership is granted for one frame at a time, starting on a sof beat.
// Requesters alternate round-robin when both are waiting. The winning
// stream passes through a single registered output stage with valid/busy
// flow control.
module datapath_frame_arbiter #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 24
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] data_in0,
  input  logic              valid_in0,
  input  logic              sof_in0,
  output logic              busy_out0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic              valid_in1,
  input  logic              sof_in1,
  output logic              busy_out1,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic              sof_out,
  input  logic              busy_in,
  output logic [1:0]        grant,
  output logic              frame_done,
  output logic              err_trunc
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic              last_reg, last_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              frame_done_next, err_trunc_next;

  logic              ready;
  logic              accept;
  logic              owner;
  logic              sel_valid, sel_sof;
  logic [DATA_W-1:0] sel_data;

  // Per-requester views so the idle logic is written once for both ports.
  logic [1:0] valid_vec, sof_vec, start_vec, idle_busy_vec;
  assign valid_vec = {valid_in1, valid_in0};
  assign sof_vec   = {sof_in1, sof_in0};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      // A waiting sof beat requests ownership; non-sof beats are drained.
      assign start_vec[gi]     = valid_vec[gi] && sof_vec[gi];
      assign idle_busy_vec[gi] = !(valid_vec[gi] && !sof_vec[gi]);
    end
  endgenerate

  // The output register can take a new beat when empty or draining.
  assign ready = !valid_out || !busy_in;

  // Owner-side mux of the incoming stream.
  assign owner     = (state_reg == OWN1);
  assign sel_valid = owner ? valid_in1 : valid_in0;
  assign sel_sof   = owner ? sof_in1   : sof_in0;
  assign sel_data  = owner ? data_in1  : data_in0;

  assign grant = {state_reg == OWN1, state_reg == OWN0};

  // Next-state, handshake and beat-counter logic.
  always_comb begin
    state_next      = state_reg;
    last_next       = last_reg;
    cnt_next        = cnt_reg;
    busy_out0       = 1'b1;
    busy_out1       = 1'b1;
    accept          = 1'b0;
    frame_done_next = 1'b0;
    err_trunc_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        busy_out0 = idle_busy_vec[0];
        busy_out1 = idle_busy_vec[1];
        cnt_next  = '0;
        if (start_vec[0] && start_vec[1]) begin
          // Tie: the requester that did not own the last frame wins.
          state_next = last_reg ? OWN0 : OWN1;
        end else if (start_vec[0]) begin
          state_next = OWN0;
        end else if (start_vec[1]) begin
          state_next = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (owner) busy_out1 = !ready;
        else       busy_out0 = !ready;
        accept = sel_valid && ready;
        if (accept) begin
          if (sel_sof && (cnt_reg != '0)) begin
            // Early sof restarts the frame count from this beat.
            cnt_next       = ONE_CNT;
            err_trunc_next = 1'b1;
          end else if (cnt_reg == LAST_CNT) begin
            state_next      = IDLE;
            last_next       = owner;
            cnt_next        = '0;
            frame_done_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + ONE_CNT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Arbiter state, last owner and beat counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Registered output stage plus one-cycle status pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      data_out   <= '0;
      valid_out  <= 1'b0;
      sof_out    <= 1'b0;
      frame_done <= 1'b0;
      err_trunc  <= 1'b0;
    end else begin
      frame_done <= frame_done_next;
      err_trunc  <= err_trunc_next;
      if (accept) begin
        data_out  <= sel_data;
        sof_out   <= sel_sof;
        valid_out <= 1'b1;
      end else if (ready) begin
        valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_datapath_frame_arbiter.sv
// Directed bench for datapath_frame_arbiter: queue-driven requesters, an
// output monitor that logs every transfer, and expected frames built by hand.
module tb_datapath_frame_arbiter;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] data_in0, data_in1, data_out;
  logic       valid_in0, valid_in1, sof_in0, sof_in1;
  logic       busy_out0, busy_out1;
  logic       valid_out, sof_out, busy_in, frame_done, err_trunc;
  logic [1:0] grant;

  datapath_frame_arbiter #(.DATA_W(8), .FRAME_LEN(24)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .data_in0(data_in0), .valid_in0(valid_in0), .sof_in0(sof_in0), .busy_out0(busy_out0),
    .data_in1(data_in1), .valid_in1(valid_in1), .sof_in1(sof_in1), .busy_out1(busy_out1),
    .data_out(data_out), .valid_out(valid_out), .sof_out(sof_out), .busy_in(busy_in),
    .grant(grant), .frame_done(frame_done), .err_trunc(err_trunc)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;

  // Source queues {sof,data}, observed transfers and expected transfers
  // {err_trunc,frame_done,sof,data}.
  logic [8:0]  q0[$];
  logic [8:0]  q1[$];
  logic [10:0] outq[$];
  logic [10:0] expq[$];
  int pops0 = 0, pops1 = 0;
  int stab_err = 0, lose_err = 0, fd_cnt = 0, et_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Requester 0: present queue head, pop after each accepted beat.
  initial begin : drv0
    logic acc;
    valid_in0 = 1'b0; sof_in0 = 1'b0; data_in0 = '0;
    forever begin
      @(negedge i_clk);
      acc = valid_in0 && !busy_out0;
      @(posedge i_clk); #1;
      if (acc && q0.size() > 0) begin void'(q0.pop_front()); pops0++; end
      if (q0.size() > 0) begin valid_in0 = 1'b1; {sof_in0, data_in0} = q0[0]; end
      else begin valid_in0 = 1'b0; sof_in0 = 1'b0; data_in0 = '0; end
    end
  end

  // Requester 1: same behaviour on port 1.
  initial begin : drv1
    logic acc;
    valid_in1 = 1'b0; sof_in1 = 1'b0; data_in1 = '0;
    forever begin
      @(negedge i_clk);
      acc = valid_in1 && !busy_out1;
      @(posedge i_clk); #1;
      if (acc && q1.size() > 0) begin void'(q1.pop_front()); pops1++; end
      if (q1.size() > 0) begin valid_in1 = 1'b1; {sof_in1, data_in1} = q1[0]; end
      else begin valid_in1 = 1'b0; sof_in1 = 1'b0; data_in1 = '0; end
    end
  end

  // Output monitor: logs transfers, pulses, stalls and non-owner leaks.
  initial begin : mon
    logic pv, pb;
    logic [8:0] pd;
    pv = 1'b0; pb = 1'b0; pd = '0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (pv && pb && (!valid_out || {sof_out, data_out} != pd)) stab_err++;
        if (valid_out && !busy_in) outq.push_back({err_trunc, frame_done, sof_out, data_out});
        if (frame_done) fd_cnt++;
        if (err_trunc) et_cnt++;
        if (valid_in1 && !busy_out1 && grant == 2'b01) lose_err++;
        if (valid_in0 && !busy_out0 && grant == 2'b10) lose_err++;
      end
      pv = valid_out && !i_rst;
      pb = busy_in;
      pd = {sof_out, data_out};
    end
  end

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1; busy_in = 1'b0;
    q0.delete(); q1.delete();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    outq.delete(); expq.delete();
    fd_cnt = 0; et_cnt = 0;
  endtask

  task automatic send(input int k, input logic s, input logic [7:0] d);
    if (k == 0) q0.push_back({s, d});
    else        q1.push_back({s, d});
  endtask

  task automatic send_frame(input int k, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      send(k, i == 0, base + 8'(i));
      expq.push_back({1'b0, i == n - 1, i == 0, base + 8'(i)});
    end
  endtask

  task automatic wait_out(input string tag, input int n);
    int c = 0;
    while (outq.size() < n && c < 600) begin @(negedge i_clk); c++; end
    repeat (4) @(negedge i_clk);
    check(tag, outq.size(), n);
  endtask

  task automatic cmp(input string tag, input logic [10:0] mask);
    for (int i = 0; i < expq.size(); i++)
      if (i < outq.size())
        check($sformatf("%s[%0d]", tag, i), int'(outq[i] & mask), int'(expq[i] & mask));
    $display("frame %s: %0d beats observed, %0d expected", tag, outq.size(), expq.size());
  endtask

  initial begin : main
    int p1;
    logic [7:0] d;
    busy_in = 1'b0;

    // Reset values.
    do_reset();
    check("rst_valid_out", valid_out, 0);
    check("rst_sof_out", sof_out, 0);
    check("rst_data_out", data_out, 0);
    check("rst_grant", grant, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_err_trunc", err_trunc, 0);
    check("rst_busy_out0", busy_out0, 1);
    check("rst_busy_out1", busy_out1, 1);

    // Single frame, 00x3 / FFx3 pattern, with latency checks.
    for (int i = 0; i < 24; i++) begin
      d = ((i / 3) % 2 == 1) ? 8'hFF : 8'h00;
      send(0, i == 0, d);
      expq.push_back({1'b0, i == 23, i == 0, d});
    end
    @(posedge i_clk); #2;
    check("lat_grant_c0", grant, 0);
    check("lat_busy0_c0", busy_out0, 1);
    @(posedge i_clk); #2;
    check("lat_grant_c1", grant, 1);
    check("lat_valid_c1", valid_out, 0);
    @(posedge i_clk); #2;
    check("lat_valid_c2", valid_out, 1);
    check("lat_sof_c2", sof_out, 1);
    wait_out("single_cnt", 24);
    cmp("single", 11'h7FF);
    check("single_grant_after", grant, 0);
    check("single_fd_cnt", fd_cnt, 1);

    // Contention: round-robin r0, r1, r0.
    do_reset();
    lose_err = 0;
    send_frame(0, 8'h1F, 24);
    send_frame(1, 8'h3F, 24);
    send_frame(0, 8'h1F, 24);
    wait_out("contend_cnt", 72);
    cmp("contend", 11'h7FF);
    check("contend_loser_busy", lose_err, 0);
    check("contend_fd_cnt", fd_cnt, 3);

    // Backpressure: busy_in 1 for 8 cycles, 0 for 8 cycles.
    do_reset();
    stab_err = 0;
    send_frame(0, 8'hA0, 24);
    for (int c = 0; c < 400 && outq.size() < 24; c++) begin
      @(posedge i_clk); #1;
      busy_in = ((c / 8) % 2 == 0);
    end
    @(posedge i_clk); #1;
    busy_in = 1'b0;
    wait_out("bp_cnt", 24);
    cmp("bp", 11'h1FF);
    check("bp_stable", stab_err, 0);

    // Resync: three stray beats on r1 are drained, then its frame passes.
    do_reset();
    p1 = pops1;
    send(1, 1'b0, 8'hAA);
    send(1, 1'b0, 8'hBB);
    send(1, 1'b0, 8'hCC);
    send_frame(1, 8'h3F, 24);
    wait_out("resync_cnt", 24);
    cmp("resync", 11'h7FF);
    check("resync_pops", pops1 - p1, 27);

    // Truncation: second sof on beat 10, frame ends 24 beats later.
    do_reset();
    for (int i = 0; i < 34; i++) begin
      send(0, i == 0 || i == 10, 8'(i));
      expq.push_back({i == 10, i == 33, i == 0 || i == 10, 8'(i)});
    end
    wait_out("trunc_cnt", 34);
    cmp("trunc", 11'h7FF);
    check("trunc_et_cnt", et_cnt, 1);
    check("trunc_fd_cnt", fd_cnt, 1);
    check("trunc_grant_after", grant, 0);

    // Reset mid-frame: outputs clear without a clock edge.
    do_reset();
    send_frame(0, 8'h40, 24);
    for (int c = 0; c < 200 && outq.size() < 12; c++) @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    check("midrst_valid_out", valid_out, 0);
    check("midrst_sof_out", sof_out, 0);
    check("midrst_data_out", data_out, 0);
    check("midrst_grant", grant, 0);
    q0.delete(); q1.delete();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    outq.delete(); expq.delete(); fd_cnt = 0;
    send_frame(0, 8'h60, 24);
    @(posedge i_clk); @(posedge i_clk); #2;
    check("midrst_regrant", grant, 1);
    wait_out("midrst_cnt", 24);
    cmp("midrst", 11'h7FF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
